// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the data memory controller.
// Holds the FSM encoding, command bit encoding and default widths.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int WAIT_W     = 4;

endpackage

// File: rtl/dm_ram.sv
// dm_ram: synchronous single-port array, registered read, no reset.
// Read data only changes on an enabled read, so it holds between reads.
module dm_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: valid/ready data memory front end with programmable wait states.
// Accepted commands are latched, delayed WAIT_STATES cycles, then applied to dm_ram.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              access;
    logic              ram_en;
    logic              rd_resp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (we_q == CMD_READ) begin
                    rdata_d = ram_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset on the access edge must keep the array untouched.
    assign ram_en    = access & rst_n;
    assign rd_resp   = (state_q == RESP) && (we_q == CMD_READ);
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rdata_oe  = rd_resp;
    assign rdata     = rd_resp ? ram_rdata : rdata_q;

    dm_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (we_q),
        .en   (ram_en),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= CMD_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed bench for two builds (WAIT_STATES 2 and 0).
// A cycle-level transaction model is compared against both DUTs every cycle.
module tb_data_mem_ctrl;

    localparam int WS [2] = '{2, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cv   [2];
    logic       cwe  [2];
    logic [7:0] ca   [2];
    logic [7:0] cwd  [2];
    logic       rdy  [2];
    logic       rsp  [2];
    logic [7:0] rd   [2];
    logic       oe_s [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    bit         pend     [2];
    bit         pwe      [2];
    logic [7:0] pa       [2];
    logic [7:0] pd       [2];
    int         acc_cyc  [2];
    int         resp_cyc [2];
    logic [7:0] rd_exp   [2];
    bit         rd_known [2];
    logic [7:0] mmem     [2][256];
    bit         mknown   [2][256];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv[0]), .cmd_we(cwe[0]), .cmd_addr(ca[0]), .cmd_wdata(cwd[0]),
        .cmd_ready(rdy[0]), .rsp_valid(rsp[0]), .rdata(rd[0]), .rdata_oe(oe_s[0])
    );

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv[1]), .cmd_we(cwe[1]), .cmd_addr(ca[1]), .cmd_wdata(cwd[1]),
        .cmd_ready(rdy[1]), .rsp_valid(rsp[1]), .rdata(rd[1]), .rdata_oe(oe_s[1])
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Transaction model: accept when idle, access WS+1 cycles later, respond one after.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pend[d]     = 1'b0;
                rd_exp[d]   = 8'h00;
                rd_known[d] = 1'b1;
            end else if (pend[d]) begin
                if (cyc == acc_cyc[d]) begin
                    if (pwe[d]) begin
                        mmem[d][pa[d]]   = pd[d];
                        mknown[d][pa[d]] = 1'b1;
                    end else begin
                        rd_exp[d]   = mmem[d][pa[d]];
                        rd_known[d] = mknown[d][pa[d]];
                    end
                end
                if (cyc == resp_cyc[d]) pend[d] = 1'b0;
            end else if (cv[d]) begin
                pend[d]     = 1'b1;
                pwe[d]      = cwe[d];
                pa[d]       = ca[d];
                pd[d]       = cwd[d];
                acc_cyc[d]  = cyc + WS[d] + 1;
                resp_cyc[d] = cyc + WS[d] + 2;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                logic er;
                er = pend[d] && (cyc == resp_cyc[d]);
                chk($sformatf("cmd_ready[%0d]", d), 32'(rdy[d]), 32'(!pend[d]));
                chk($sformatf("rsp_valid[%0d]", d), 32'(rsp[d]), 32'(er));
                chk($sformatf("rdata_oe[%0d]", d), 32'(oe_s[d]), 32'(er && !pwe[d]));
                if (rd_known[d])
                    chk($sformatf("rdata[%0d]", d), 32'(rd[d]), 32'(rd_exp[d]));
            end
        end
    end

    task automatic send(input int d, input logic we, input logic [7:0] a,
                        input logic [7:0] wd, output int acc);
        int n;
        cv[d] = 1'b1; cwe[d] = we; ca[d] = a; cwd[d] = wd;
        n = 0;
        @(negedge clk);
        while (!rdy[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(rdy[d]), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        cv[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, output int rc, output logic [7:0] data,
                            output logic oe);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait", 32'(rsp[d]), 32'd1);
        rc = cyc; data = rd[d]; oe = oe_s[d];
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, rc, cnt;
        int accs [4];
        logic [7:0] data;
        logic oe;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cv[d] = 1'b1; cwe[d] = 1'b1; ca[d] = 8'h10; cwd[d] = 8'hEE;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(rdy[0]), 32'd1);
            chk("rst_rsp", 32'(rsp[0]), 32'd0);
            chk("rst_rdata", 32'(rd[0]), 32'h00);
            chk("rst_oe", 32'(oe_s[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cv[0] = 1'b0;
        cv[1] = 1'b0;

        // write then read back, WAIT_STATES = 2
        send(0, 1'b1, 8'h10, 8'hA5, acc);
        wait_rsp(0, rc, data, oe);
        chk("wr_latency", 32'(rc - acc), 32'd4);
        chk("wr_oe", 32'(oe), 32'd0);
        send(0, 1'b0, 8'h10, 8'h00, acc);
        wait_rsp(0, rc, data, oe);
        chk("rd_latency", 32'(rc - acc), 32'd4);
        chk("rd_data_10", 32'(data), 32'hA5);
        chk("rd_oe", 32'(oe), 32'd1);

        // back-to-back writes with cmd_valid kept high
        for (int i = 0; i < 4; i++) send(0, 1'b1, 8'(i), 8'h30 + 8'(i), accs[i]);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'd5);
        for (int i = 0; i < 4; i++) begin
            send(0, 1'b0, 8'(i), 8'h00, acc);
            wait_rsp(0, rc, data, oe);
            chk("b2b_readback", 32'(data), 32'h30 + 32'(i));
        end

        // boundary addresses
        send(0, 1'b1, 8'hFF, 8'h3C, acc);
        send(0, 1'b1, 8'h00, 8'hC3, acc);
        send(0, 1'b0, 8'hFF, 8'h00, acc);
        wait_rsp(0, rc, data, oe);
        chk("rd_ff", 32'(data), 32'h3C);
        send(0, 1'b0, 8'h00, 8'h00, acc);
        wait_rsp(0, rc, data, oe);
        chk("rd_00", 32'(data), 32'hC3);

        // reset one cycle after a write is accepted
        send(0, 1'b1, 8'h20, 8'h11, acc);
        wait_rsp(0, rc, data, oe);
        send(0, 1'b1, 8'h20, 8'h77, acc);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp[0]) cnt++;
        end
        chk("abort_no_rsp", 32'(cnt), 32'd0);
        send(0, 1'b0, 8'h20, 8'h00, acc);
        wait_rsp(0, rc, data, oe);
        chk("abort_mem_kept", 32'(data), 32'h11);

        // WAIT_STATES = 0 build
        send(1, 1'b1, 8'h40, 8'h5A, acc);
        wait_rsp(1, rc, data, oe);
        chk("ws0_wr_latency", 32'(rc - acc), 32'd2);
        send(1, 1'b0, 8'h40, 8'h00, acc);
        wait_rsp(1, rc, data, oe);
        chk("ws0_rd_latency", 32'(rc - acc), 32'd2);
        chk("ws0_rd_data", 32'(data), 32'h5A);
        send(1, 1'b1, 8'h41, 8'h99, acc);
        wait_rsp(1, rc, data, oe);
        @(negedge clk);
        chk("ws0_rdata_hold", 32'(rd[1]), 32'h5A);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Single-port data memory with a valid/ready command handshake and a programmable number of wait states. It sits directly downstream of the memory interface. It consumes that interface's command bit (0 = read, 1 = write), address and write data, and returns read data plus a one-cycle response strobe. The data output comes with an output-enable so the top level can drive the shared bidirectional data bus.

## Interface
- ADDR_W, 8, address width; memory depth is 2^ADDR_W words
- DATA_W, 8, word width
- WAIT_STATES, 2, extra busy cycles per access (0..15 legal)
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- cmd_valid  in  1  command present
- cmd_we  in  1  0 = read, 1 = write (same encoding as the memory interface's command bit)
- cmd_addr  in  ADDR_W  word address
- cmd_wdata  in  DATA_W  write data, sampled with the command
- cmd_ready  out  1  block can accept a command this cycle
- rsp_valid  out  1  one-cycle strobe: access completed
- rdata  out  DATA_W  read data register
- rdata_oe  out  1  high while rdata must be driven onto the shared data bus

## Operation
- FSM states: IDLE, BUSY, RESP; encoded in the package.
- IDLE:
  - cmd_ready = 1; cmd_ready is combinational, (state == IDLE).
  - On cmd_valid & cmd_ready, latch cmd_we, cmd_addr and cmd_wdata; load wait counter with WAIT_STATES; go to BUSY.
- BUSY:
  - If counter != 0, decrement it and stay in BUSY.
  - If counter == 0, perform the access on this edge and go to RESP.
  - Write: mem[addr] <= wdata.
  - Read: rdata <= mem[addr].
- RESP: rsp_valid = 1 for exactly this cycle; rdata_oe = 1 only for a read; next state IDLE.
- No queuing. A cmd_valid asserted while cmd_ready = 0 is ignored, and the master holds it until accepted.
- rdata holds its last read value through writes and idle periods. Only a completed read updates it.
- Every address 0 .. 2^ADDR_W-1 is valid; no range error exists.
- Memory contents are not reset. Read-before-write returns X in simulation, and the bench must not check it.

## Timing
- Reset values:
  - state = IDLE, so cmd_ready = 1 in the first cycle after reset.
  - rsp_valid = 0, rdata_oe = 0, rdata = 0, counter = 0.
- Latency: a command accepted in cycle N gives rsp_valid in cycle N+WAIT_STATES+2.
- cmd_ready is low in cycles N+1 .. N+WAIT_STATES+2 and returns high in cycle N+WAIT_STATES+3.
- Throughput: one command per WAIT_STATES+3 cycles.
- WAIT_STATES = 0: BUSY lasts one cycle; rsp_valid is in cycle N+2.
- Read data: rdata is valid from the RESP cycle onward; rdata_oe coincides exactly with rsp_valid on reads.
- Reset mid-operation, on any edge with rst_n = 0:
  - Return to IDLE and drop any pending access.
  - A write not yet performed (reset on or before the access edge) leaves memory unchanged.
  - rsp_valid is never asserted for the abandoned command.
- Reset and cmd_valid in the same cycle: reset wins; the command is not accepted.
- Write followed by a read of the same address: the read returns the new data (accesses are strictly sequential).

## Structure
- Package dm_pkg:
  - state enum (IDLE, BUSY, RESP)
  - CMD_READ = 1'b0, CMD_WRITE = 1'b1
  - default ADDR_W / DATA_W
  - WAIT_W = 4, the counter width
- Sub-module dm_ram: synchronous single-port array with parameters ADDR_W and DATA_W.
  - Ports: clk, we, en, addr, wdata, rdata.
  - No reset.
  - Read is registered, one edge.
- data_mem_ctrl holds the FSM, the command latch, the wait counter and the response registers. It pulses the dm_ram enable only on the BUSY counter==0 edge.

## Test plan
- Reset → cmd_ready = 1, rsp_valid = 0, rdata = 0x00, rdata_oe = 0. Hold rst_n low 3 cycles with cmd_valid = 1 → no response.
- Write 0xA5 to 0x10 (accepted cycle N, WAIT_STATES = 2) → rsp_valid only in cycle N+4, rdata_oe = 0; read 0x10 → rdata = 0xA5 with rsp_valid & rdata_oe.
- Back-to-back: cmd_valid held high with writes to 0x00..0x03 → each accepted exactly 5 cycles apart; cmd_ready low in between; readback gives all four values.
- Boundary addresses: write 0x3C to 0xFF and 0xC3 to 0x00, then read both → 0x3C and 0xC3, no aliasing.
- Reset asserted in the cycle after a write to 0x20 (data 0x77, previous content 0x11) is accepted → after reset, read 0x20 returns 0x11 and no rsp_valid occurs for the aborted write.
- WAIT_STATES = 0 build: read accepted cycle N → rsp_valid in cycle N+2; rdata holds its value through a following write.
